regfile_cmd_ctrl: RTL and testbench
===================================

// Module: regfile_cmd_ctrl
// PURPOSE
//  Command-side initiator for the system register file. Parses a byte stream from the UART RX path
//  (write: 0xAA,addr,data; read: 0xBB,addr) and drives WrEn/RdEn/Address/WrData.
//  Read results are returned as one byte to the UART TX FIFO, honouring TX_FULL backpressure.
//  Sits between UART RX and the register file, and between the register file and the TX FIFO.
// PARAMETERS
//  WIDTH       8      data/command byte width
//  DEPTH       16     register file depth
//  ADDR        $clog2(DEPTH)  address width
//  WR_CMD      8'hAA  write opcode
//  RD_CMD      8'hBB  read opcode
//  RD_TIMEOUT  4      max cycles in RD_WAIT for RdData_VLD
// PORTS
//  CLK         in   1      clock, rising edge
//  RST         in   1      reset, asynchronous, active-low
//  RX_P_DATA   in   WIDTH  received byte
//  RX_D_VLD    in   1      1-cycle strobe, RX_P_DATA valid
//  RdData      in   WIDTH  register file read data
//  RdData_VLD  in   1      register file read-data valid
//  TX_FULL     in   1      TX FIFO full; no push while high
//  WrEn        out  1      register file write strobe
//  RdEn        out  1      register file read strobe
//  Address     out  ADDR   register file address
//  WrData      out  WIDTH  register file write data
//  TX_P_DATA   out  WIDTH  byte pushed to TX FIFO
//  TX_D_VLD    out  1      1-cycle push strobe to TX FIFO
//  CMD_ERR     out  1      1-cycle error pulse
// BEHAVIOUR
//  - All outputs registered. Reset value of every output is 0; state = IDLE; timeout counter = 0.
//  - WrEn and RdEn are never high in the same cycle. Each is high for exactly 1 cycle per command.
//  - FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND. Bytes are consumed only on RX_D_VLD.
//  - IDLE: byte==WR_CMD -> WR_ADDR; byte==RD_CMD -> RD_ADDR; any other byte -> CMD_ERR pulse, stay IDLE.
//  - WR_ADDR / RD_ADDR: if byte >= DEPTH -> CMD_ERR pulse, go to IDLE.
//    Otherwise latch byte[ADDR-1:0] into Address, then WR_ADDR -> WR_DATA, or RD_ADDR -> RdEn=1 next cycle -> RD_WAIT.
//  - WR_DATA: the byte is latched into WrData and WrEn=1 in the next cycle, then -> IDLE.
//    Latency is 1 cycle from the data byte's RX_D_VLD to WrEn.
//  - RD_WAIT: on RdData_VLD, capture RdData into TX_P_DATA -> TX_SEND.
//    If RD_TIMEOUT cycles pass without RdData_VLD -> CMD_ERR pulse, go to IDLE.
//  - TX_SEND: when TX_FULL==0, TX_D_VLD=1 for 1 cycle, then -> IDLE. While TX_FULL==1, hold state and TX_P_DATA.
//  - Nominal read latency: addr RX_D_VLD at N -> RdEn N+1 -> RdData_VLD N+2 -> TX_D_VLD N+3 (TX not full).
//  - RX_D_VLD in RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulse; the current command is unaffected.
//  - Address holds its last value between commands. WrData changes only in WR_DATA.
//  - Reset mid-command aborts it immediately: no pending WrEn/RdEn/TX_D_VLD is issued after reset release.
//  - CMD_ERR events in the same cycle produce a single 1-cycle pulse.
// STRUCTURE
//  - Shared package (sys_ctrl_pkg): WR_CMD/RD_CMD opcode constants and the FSM state encoding
//    (localparams, 3-bit binary). Both are reused by any later ALU-command controller.
//  - No sub-module. The timeout counter ($clog2(RD_TIMEOUT+1) bits) is inline, cleared on entering RD_WAIT.
// TESTING
//  - Write then read, regfile model attached. RX AA,05,3C -> WrEn=1 1 cycle, Address=5, WrData=3C.
//    Then BB,05 -> RdEn 1 cycle, TX_P_DATA=3C, TX_D_VLD at N+3.
//  - Reset-default read. RX BB,02 -> TX byte 0x81. RX BB,03 -> TX byte 0x20.
//  - Bad opcode / address. RX 0x55 -> CMD_ERR 1 cycle, no WrEn/RdEn. RX AA,10 -> CMD_ERR, IDLE.
//    Then AA,01,77 -> REG1=0x77.
//  - Backpressure. TX_FULL=1 during BB,04 -> TX_D_VLD stays 0 and TX_P_DATA holds.
//    Release TX_FULL -> exactly one TX_D_VLD.
//  - Timeout. Model suppresses RdData_VLD -> CMD_ERR after 4 cycles in RD_WAIT, no TX_D_VLD.
//    Next command is processed normally.
//  - Reset mid-op. Assert RST after AA,06 (before data) -> all outputs 0, no WrEn.
//    Post-reset BB,06 returns 0x00.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the system command controllers: the UART command opcodes and the
// command FSM state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] WrCmd = 8'hAA;
  localparam logic [7:0] RdCmd = 8'hBB;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] StIdle   = 3'd0;
  localparam logic [StateW-1:0] StWrAddr = 3'd1;
  localparam logic [StateW-1:0] StWrData = 3'd2;
  localparam logic [StateW-1:0] StRdAddr = 3'd3;
  localparam logic [StateW-1:0] StRdWait = 3'd4;
  localparam logic [StateW-1:0] StTxSend = 3'd5;

endpackage

// File: rtl/regfile_cmd_ctrl.sv
// UART command parser driving the system register file: write (AA,addr,data) and read (BB,addr)
// commands; read data is returned as a single byte to the TX FIFO.
module regfile_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned     WIDTH      = 8,
  parameter int unsigned     DEPTH      = 16,
  parameter int unsigned     ADDR       = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] WR_CMD    = WIDTH'(WrCmd),
  parameter logic [WIDTH-1:0] RD_CMD    = WIDTH'(RdCmd),
  parameter int unsigned     RD_TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             TX_FULL,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             CMD_ERR
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RD_TIMEOUT - 1);
  localparam logic [WIDTH:0]  DepthW  = (WIDTH + 1)'(DEPTH);

  logic [StateW-1:0] state_q, state_d;
  logic [CntW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR-1:0]   address_q, address_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [WIDTH-1:0]  tx_p_data_q, tx_p_data_d;
  logic              tx_d_vld_q, tx_d_vld_d;
  logic              cmd_err_q, cmd_err_d;
  logic              addr_oob;

  // Widen by one bit so DEPTH == 2**WIDTH still compares correctly.
  assign addr_oob = ({1'b0, RX_P_DATA} >= DepthW);

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    tx_p_data_d = tx_p_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_d_vld_d  = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = StWrAddr;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = StRdAddr;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      StWrAddr, StRdAddr: begin
        if (RX_D_VLD) begin
          if (addr_oob) begin
            cmd_err_d = 1'b1;
            state_d   = StIdle;
          end else begin
            address_d = RX_P_DATA[ADDR-1:0];
            if (state_q == StWrAddr) begin
              state_d = StWrData;
            end else begin
              rd_en_d   = 1'b1;
              tmo_cnt_d = '0;
              state_d   = StRdWait;
            end
          end
        end
      end

      StWrData: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = StIdle;
        end
      end

      StRdWait: begin
        // A byte arriving mid-read is dropped but flagged.
        cmd_err_d = RX_D_VLD;
        if (RdData_VLD) begin
          tx_p_data_d = RdData;
          // Push straight away when the FIFO has room, keeping the nominal latency.
          if (!TX_FULL) begin
            tx_d_vld_d = 1'b1;
            state_d    = StIdle;
          end else begin
            state_d = StTxSend;
          end
        end else if (tmo_cnt_q == CntLast) begin
          cmd_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      StTxSend: begin
        cmd_err_d = RX_D_VLD;
        if (!TX_FULL) begin
          tx_d_vld_d = 1'b1;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      address_q   <= '0;
      wr_data_q   <= '0;
      tx_p_data_q <= '0;
      tx_d_vld_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      tx_p_data_q <= tx_p_data_d;
      tx_d_vld_q  <= tx_d_vld_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_p_data_q;
  assign TX_D_VLD  = tx_d_vld_q;
  assign CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a small register-file model answering reads one
// cycle after RdEn.
module tb_regfile_cmd_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned ADDR  = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] RX_P_DATA = '0;
  logic             RX_D_VLD = 1'b0;
  logic [WIDTH-1:0] RdData;
  logic             RdData_VLD;
  logic             TX_FULL = 1'b0;
  logic             WrEn, RdEn, TX_D_VLD, CMD_ERR;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData, TX_P_DATA;

  int checks = 0;
  int failures = 0;
  int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
  logic suppress = 1'b0;

  always #5 CLK = ~CLK;

  regfile_cmd_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR),
    .WR_CMD(8'hAA), .RD_CMD(8'hBB), .RD_TIMEOUT(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_VLD(RdData_VLD), .TX_FULL(TX_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
  );

  // Register file model: REG2/REG3 have non-zero reset defaults.
  logic [WIDTH-1:0] regs [DEPTH];
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      regs[2]    <= 8'h81;
      regs[3]    <= 8'h20;
      RdData     <= '0;
      RdData_VLD <= 1'b0;
    end else begin
      RdData_VLD <= RdEn && !suppress;
      if (RdEn) RdData <= regs[Address];
      if (WrEn) regs[Address] <= WrData;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    checks++;
    if (WrEn && RdEn) begin
      failures++;
      $display("FAIL strobe_excl: WrEn=%b RdEn=%b, required not both high", WrEn, RdEn);
    end
    if (WrEn) n_wr++;
    if (RdEn) n_rd++;
    if (TX_D_VLD) n_tx++;
    if (CMD_ERR) n_err++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    tick();
  endtask

  // Returns the first TX byte and its latency in ticks after the address byte (-1 if none).
  task automatic do_read(input logic [7:0] a, output logic [7:0] got, output int lat);
    got = 8'hxx;
    lat = -1;
    send_byte(8'hBB);
    send_byte(a);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (TX_D_VLD && lat < 0) begin
        lat = i;
        got = TX_P_DATA;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks += 7;
    if (WrEn !== 1'b0)     begin failures++; $display("FAIL rst_wren: got %b want 0", WrEn); end
    if (RdEn !== 1'b0)     begin failures++; $display("FAIL rst_rden: got %b want 0", RdEn); end
    if (Address !== 4'h0)  begin failures++; $display("FAIL rst_addr: got %h want 0", Address); end
    if (WrData !== 8'h00)  begin failures++; $display("FAIL rst_wrdata: got %h want 00", WrData); end
    if (TX_P_DATA !== 8'h00) begin failures++; $display("FAIL rst_txdata: got %h want 00", TX_P_DATA); end
    if (TX_D_VLD !== 1'b0) begin failures++; $display("FAIL rst_txvld: got %b want 0", TX_D_VLD); end
    if (CMD_ERR !== 1'b0)  begin failures++; $display("FAIL rst_err: got %b want 0", CMD_ERR); end
    #1 RST = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int rd0, tx0, wr0;
    wr0 = n_wr;
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    checks += 4;
    if (WrEn !== 1'b1)    begin failures++; $display("FAIL wr_en: got %b want 1", WrEn); end
    if (Address !== 4'h5) begin failures++; $display("FAIL wr_addr: got %h want 5", Address); end
    if (WrData !== 8'h3C) begin failures++; $display("FAIL wr_data: got %h want 3c", WrData); end
    tick();
    if (WrEn !== 1'b0)    begin failures++; $display("FAIL wr_pulse: got %b want 0", WrEn); end
    checks++;
    if (n_wr - wr0 != 1)  begin failures++; $display("FAIL wr_count: got %0d want 1", n_wr - wr0); end
    send_byte(8'hBB);
    rd0 = n_rd;
    tx0 = n_tx;
    send_byte(8'h05);
    checks += 2;
    if (RdEn !== 1'b1)     begin failures++; $display("FAIL rd_en: got %b want 1", RdEn); end
    if (TX_D_VLD !== 1'b0) begin failures++; $display("FAIL rd_early_tx: got %b want 0", TX_D_VLD); end
    tick();
    checks += 2;
    if (RdEn !== 1'b0)     begin failures++; $display("FAIL rd_pulse: got %b want 0", RdEn); end
    if (TX_D_VLD !== 1'b0) begin failures++; $display("FAIL rd_n2_tx: got %b want 0", TX_D_VLD); end
    tick();
    checks += 2;
    if (TX_D_VLD !== 1'b1)    begin failures++; $display("FAIL rd_n3_tx: got %b want 1", TX_D_VLD); end
    if (TX_P_DATA !== 8'h3C)  begin failures++; $display("FAIL rd_data: got %h want 3c", TX_P_DATA); end
    tick();
    tick();
    checks += 3;
    if (TX_D_VLD !== 1'b0) begin failures++; $display("FAIL rd_tx_pulse: got %b want 0", TX_D_VLD); end
    if (n_rd - rd0 != 1)   begin failures++; $display("FAIL rd_count: got %0d want 1", n_rd - rd0); end
    if (n_tx - tx0 != 1)   begin failures++; $display("FAIL tx_count: got %0d want 1", n_tx - tx0); end
  endtask

  task automatic test_reset_defaults();
    logic [7:0] got;
    int lat;
    do_read(8'h02, got, lat);
    checks += 2;
    if (got !== 8'h81) begin failures++; $display("FAIL def_reg2: got %h want 81", got); end
    if (lat != 2)      begin failures++; $display("FAIL def_reg2_lat: got %0d want 2", lat); end
    do_read(8'h03, got, lat);
    checks++;
    if (got !== 8'h20) begin failures++; $display("FAIL def_reg3: got %h want 20", got); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] got;
    int lat;
    send_byte(8'h55);
    checks += 4;
    if (CMD_ERR !== 1'b1) begin failures++; $display("FAIL badop_err: got %b want 1", CMD_ERR); end
    if (WrEn !== 1'b0 || RdEn !== 1'b0) begin
      failures++; $display("FAIL badop_strobe: got wr=%b rd=%b want 0 0", WrEn, RdEn);
    end
    if (Address !== 4'h3) begin failures++; $display("FAIL addr_hold: got %h want 3", Address); end
    tick();
    if (CMD_ERR !== 1'b0) begin failures++; $display("FAIL badop_pulse: got %b want 0", CMD_ERR); end
    send_byte(8'hAA);
    send_byte(8'h10);
    checks++;
    if (CMD_ERR !== 1'b1) begin failures++; $display("FAIL badaddr_err: got %b want 1", CMD_ERR); end
    tick();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h77);
    checks += 2;
    if (WrEn !== 1'b1 || Address !== 4'h1) begin
      failures++; $display("FAIL post_err_wr: got en=%b addr=%h want 1 1", WrEn, Address);
    end
    if (WrData !== 8'h77) begin failures++; $display("FAIL post_err_data: got %h want 77", WrData); end
    tick();
    do_read(8'h01, got, lat);
    checks++;
    if (got !== 8'h77) begin failures++; $display("FAIL reg1_read: got %h want 77", got); end
  endtask

  task automatic test_backpressure();
    int tx0;
    do_write(8'h04, 8'h5A);
    TX_FULL = 1'b1;
    tx0 = n_tx;
    send_byte(8'hBB);
    send_byte(8'h04);
    tick();
    tick();
    checks += 2;
    if (TX_P_DATA !== 8'h5A) begin failures++; $display("FAIL bp_data: got %h want 5a", TX_P_DATA); end
    if (TX_D_VLD !== 1'b0)   begin failures++; $display("FAIL bp_vld: got %b want 0", TX_D_VLD); end
    send_byte(8'h11);
    checks++;
    if (CMD_ERR !== 1'b1) begin failures++; $display("FAIL bp_stray_err: got %b want 1", CMD_ERR); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h5A) begin
        failures++; $display("FAIL bp_hold: got vld=%b data=%h want 0 5a", TX_D_VLD, TX_P_DATA);
      end
    end
    TX_FULL = 1'b0;
    tick();
    checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h5A) begin
      failures++; $display("FAIL bp_release: got vld=%b data=%h want 1 5a", TX_D_VLD, TX_P_DATA);
    end
    tick();
    tick();
    checks++;
    if (n_tx - tx0 != 1) begin failures++; $display("FAIL bp_count: got %0d want 1", n_tx - tx0); end
  endtask

  task automatic test_timeout();
    int tx0;
    logic [7:0] got;
    int lat;
    suppress = 1'b1;
    tx0 = n_tx;
    send_byte(8'hBB);
    send_byte(8'h07);
    checks++;
    if (RdEn !== 1'b1) begin failures++; $display("FAIL to_rden: got %b want 1", RdEn); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (CMD_ERR !== 1'b0) begin failures++; $display("FAIL to_early_err%0d: got %b want 0", i, CMD_ERR); end
    end
    tick();
    checks++;
    if (CMD_ERR !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", CMD_ERR); end
    tick();
    checks += 2;
    if (CMD_ERR !== 1'b0) begin failures++; $display("FAIL to_err_pulse: got %b want 0", CMD_ERR); end
    if (n_tx != tx0)      begin failures++; $display("FAIL to_no_tx: got %0d want 0", n_tx - tx0); end
    suppress = 1'b0;
    do_read(8'h03, got, lat);
    checks++;
    if (got !== 8'h20 || lat != 2) begin
      failures++; $display("FAIL to_recover: got %h lat %0d want 20 lat 2", got, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    int wr0;
    logic [7:0] got;
    int lat;
    send_byte(8'hAA);
    send_byte(8'h06);
    wr0 = n_wr;
    RST = 1'b0;
    #2;
    checks++;
    if (WrEn !== 1'b0 || RdEn !== 1'b0 || Address !== 4'h0 || WrData !== 8'h00 ||
        TX_P_DATA !== 8'h00 || TX_D_VLD !== 1'b0 || CMD_ERR !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outs: got wr=%b rd=%b a=%h wd=%h td=%h tv=%b e=%b want all 0",
               WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR);
    end
    #1 RST = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (n_wr != wr0) begin failures++; $display("FAIL midrst_no_wr: got %0d want 0", n_wr - wr0); end
    do_read(8'h06, got, lat);
    checks++;
    if (got !== 8'h00) begin failures++; $display("FAIL midrst_read: got %h want 00", got); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_defaults();
    test_bad_cmd();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
